imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/byte_packer.sv | 58 +++++
 rtl/imem_loader.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// Holds the loader state encoding and the stream field widths.
package imem_loader_pkg;

    localparam int unsigned LEN_W  = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned LANE_W = 2;

    typedef enum logic [1:0] {
        ST_LEN_LO = 2'd0,
        ST_LEN_HI = 2'd1,
        ST_DATA   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/byte_packer.sv
// Byte-to-word packer: collects four bytes little-endian into a 32-bit word.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   clear_i       synchronous clear of the lane counter and assembly register
//   byte_valid_i  a byte is consumed this cycle
//   byte_i        consumed byte
//   lane_o        lane the next consumed byte lands in (0..3)
//   word_o        assembly register; holds the full word in the word_done_o cycle
//   word_done_o   one-cycle pulse the cycle after the 4th byte of a word
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear_i,
    input  logic                byte_valid_i,
    input  logic [BYTE_W-1:0]   byte_i,
    output logic [LANE_W-1:0]   lane_o,
    output logic [WORD_W-1:0]   word_o,
    output logic                word_done_o
);

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [WORD_W-1:0] asm_q,  asm_d;
    logic              done_q, done_d;

    // Each byte overwrites its own lane; the lane counter wraps 3 -> 0.
    always_comb begin
        lane_d = lane_q;
        asm_d  = asm_q;
        done_d = 1'b0;
        if (clear_i) begin
            lane_d = '0;
            asm_d  = '0;
        end else if (byte_valid_i) begin
            asm_d[BYTE_W*lane_q +: BYTE_W] = byte_i;
            lane_d = lane_q + LANE_W'(1);
            done_d = (lane_q == LANE_W'(3));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= '0;
            asm_q  <= '0;
            done_q <= 1'b0;
        end else begin
            lane_q <= lane_d;
            asm_q  <= asm_d;
            done_q <= done_d;
        end
    end

    assign lane_o      = lane_q;
    assign word_o      = asm_q;
    assign word_done_o = done_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a byte stream (16-bit word count, low byte
// first, then 4*N little-endian data bytes), writes the words to memory from
// address 0 and releases the core once the program is in.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_data      offered stream byte
//   in_ready              byte accepted this cycle when in_valid is high
//   reload                restart request, honoured only once loading is done
//   imem_we/addr/wdata    instruction-memory write port
//   core_run              high once the whole program has been consumed
//   load_err              sticky: program had more words than DEPTH
//   words_loaded          number of words written, saturating at DEPTH
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_run,
    output logic              load_err,
    output logic [15:0]       words_loaded
);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q,   len_d;
    logic [LEN_W-1:0]  idx_q,   idx_d;
    logic [LEN_W-1:0]  words_q, words_d;
    logic              ready_q, ready_d;
    logic              we_q,    we_d;
    logic              run_q,   run_d;
    logic              err_q,   err_d;

    logic              accept_c;
    logic              data_byte_c;
    logic              word_accept_c;
    logic              in_range_c;
    logic              clear_c;
    logic [LANE_W-1:0] lane;
    logic [WORD_W-1:0] word;
    logic              word_done;

    assign accept_c      = in_valid && ready_q;
    assign data_byte_c   = accept_c && (state_q == ST_DATA);
    assign word_accept_c = data_byte_c && (lane == LANE_W'(3));
    assign in_range_c    = 32'(idx_q) < DEPTH;
    assign clear_c       = (state_q == ST_DONE) && reload;

    byte_packer u_byte_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (clear_c),
        .byte_valid_i (data_byte_c),
        .byte_i       (in_data),
        .lane_o       (lane),
        .word_o       (word),
        .word_done_o  (word_done)
    );

    // Next-state and registered-output logic.
    // idx_q advances one cycle after the last byte of a word, which is always
    // before the next word can complete, so range and final-word checks at
    // word_accept_c see the index of the word being finished.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        words_d = words_q;
        we_d    = 1'b0;
        err_d   = err_q;

        if (word_done) begin
            idx_d = idx_q + LEN_W'(1);
        end
        if (we_q && (32'(words_q) < DEPTH)) begin
            words_d = words_q + LEN_W'(1);
        end

        case (state_q)
            ST_LEN_LO: begin
                if (accept_c) begin
                    len_d[7:0] = in_data;
                    state_d    = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (accept_c) begin
                    len_d[15:8] = in_data;
                    state_d     = ({in_data, len_q[7:0]} != '0) ? ST_DATA : ST_DONE;
                end
            end
            ST_DATA: begin
                if (word_accept_c) begin
                    we_d = in_range_c;
                    if (!in_range_c) begin
                        err_d = 1'b1;
                    end
                    if (idx_q == (len_q - LEN_W'(1))) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // Reload wins over the late index/count updates of the last word.
                if (reload) begin
                    state_d = ST_LEN_LO;
                    idx_d   = '0;
                    words_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ST_LEN_LO;
        endcase

        ready_d = (state_d != ST_DONE);
        run_d   = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LEN_LO;
            len_q   <= '0;
            idx_q   <= '0;
            words_q <= '0;
            ready_q <= 1'b1;
            we_q    <= 1'b0;
            run_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            words_q <= words_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            run_q   <= run_d;
            err_q   <= err_d;
        end
    end

    assign in_ready     = ready_q;
    assign imem_we      = we_q;
    assign imem_addr    = idx_q[ADDR_W-1:0];
    assign imem_wdata   = word;
    assign core_run     = run_q;
    assign load_err     = err_q;
    assign words_loaded = words_q;

endmodule
